mul_seq32: RTL



---
 rtl/mul_seq32.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mul_seq32.sv
// mul_seq32 -- iterative 32x32 unsigned shift-add multiplier, 64-bit product.
//
// One accepted operation takes 32 iterations through a single 32-bit
// lookahead adder. The adder sum and carry-out are shifted back into the
// {acc_hi, acc_lo} partial-product register each cycle.
//
// Ports:
//   clk      in   1   single clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request, accepted while busy==0
//   op1      in  32   multiplicand, captured on the accepting edge
//   op2      in  32   multiplier, captured on the accepting edge
//   busy     out  1   high while an operation is in progress (state CALC)
//   done     out  1   one-cycle pulse when product is updated (state DONE)
//   product  out 64   result register, holds until the next completion
//
// State table:
//   IDLE | waiting for start
//   CALC | one shift-add iteration per edge, cnt counts 0..31
//   DONE | product just loaded; start here is accepted immediately

module mul_seq32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] acc_hi_nxt;
  logic [31:0] acc_lo_nxt;

  assign addend = acc_lo[0] ? mcand : 32'd0;

  AdderLA32bit u_add (
    .op1  (acc_hi),
    .op2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout, sum, acc_lo} >> 1, keeping the low 64 bits: the carry-out lands
  // in the MSB so no product bit is lost.
  assign acc_hi_nxt = {cout, sum[31:1]};
  assign acc_lo_nxt = {sum[0], acc_lo[31:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      cnt     <= 5'd0;
      product <= 64'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand  <= op1;
            acc_lo <= op2;
            acc_hi <= 32'd0;
            cnt    <= 5'd0;
            state  <= S_CALC;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            product <= {acc_hi_nxt, acc_lo_nxt};
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

endmodule

// AdderLA32bit -- 32-bit carry-lookahead adder built from eight 4-bit
// lookahead groups with a group-level lookahead carry chain.
//
// Ports:
//   op1   in  32  addend A
//   op2   in  32  addend B
//   cin   in   1  carry in
//   sum   out 32  A + B + cin, low 32 bits
//   cout  out  1  carry out

module AdderLA32bit (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  always_comb begin
    g  = op1 & op2;
    p  = op1 ^ op2;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // In-group carries are expanded from the group carry-in, not rippled.
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[32] = gc[8];
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule
